// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with a valid/ready load port, global
// enable and an autonomous scan mode that walks the active line with a programmable dwell.
module onehot_scan_decoder #(
  parameter  int SEL_W   = 3,
  parameter  int DWELL_W = 8,
  localparam int OUT_W   = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out,
  output logic [SEL_W-1:0]   out_idx,
  output logic               out_valid,
  output logic               wrap
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;

  localparam logic [OUT_W-1:0] LINE0 = OUT_W'(1);

  logic [1:0]         state;
  logic [DWELL_W-1:0] cnt;
  logic               accept;

  assign in_ready = en & ~mode & (state != ST_SCAN);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out       <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      cnt       <= '0;
    end else begin
      // NOTE: non-blocking default below is overridden by later assignments in
      // the same block, giving a clean one-cycle pulse without a separate clear path.
      wrap <= 1'b0;
      if (!en) begin
        state     <= ST_IDLE;
        out       <= '0;
        out_valid <= 1'b0;
        cnt       <= '0;
      end else if (mode) begin
        if (state != ST_SCAN) begin
          state     <= ST_SCAN;
          out       <= LINE0;
          out_idx   <= '0;
          out_valid <= 1'b1;
          cnt       <= dwell;
        end else if (cnt == '0) begin
          // Rotation brings the top line back to line 0 on wrap-around.
          out     <= {out[OUT_W-2:0], out[OUT_W-1]};
          out_idx <= out_idx + SEL_W'(1);
          wrap    <= &out_idx;
          cnt     <= dwell;
        end else begin
          cnt <= cnt - DWELL_W'(1);
        end
      end else if (state == ST_SCAN) begin
        state <= ST_HOLD;
        cnt   <= '0;
      end else if (accept) begin
        state     <= ST_HOLD;
        out       <= LINE0 << in_sel;
        out_idx   <= in_sel;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/onehot_scan_decoder.md
# onehot_scan_decoder

Parametrised, registered binary-to-one-hot decoder: an SEL_W-bit index drives a 2**SEL_W-bit one-hot output. It generalises the team's combinational 3-to-8 decoder. It adds a valid/ready load port, a global enable and an autonomous scan mode that walks the active line through every output with a programmable dwell. It is used for LED/keypad row strobing and for chip-select generation behind a bus register.

## Interface
- SEL_W, 3, select width; OUT_W = 2**SEL_W output lines (derived, not overridable)
- DWELL_W, 8, width of the per-slot dwell count
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  global enable; 0 forces outputs idle
- mode  input  1  0 = DIRECT (load index), 1 = SCAN (auto-walk)
- in_valid  input  1  in_sel is valid this cycle
- in_ready  output  1  block accepts in_sel this cycle
- in_sel  input  SEL_W  index to decode
- dwell  input  DWELL_W  scan slot length minus one, in cycles
- out  output  OUT_W  one-hot decoded lines, registered
- out_idx  output  SEL_W  binary index of the active line
- out_valid  output  1  out holds a live one-hot value
- wrap  output  1  one-cycle pulse when the scan returns to index 0

## Operation
- States:
  - IDLE: out = 0.
  - HOLD: a static one-hot value is held.
  - SCAN: the active line is walking.
- Reset (asynchronous, immediate): state IDLE, out = 0, out_idx = 0, out_valid = 0, wrap = 0, dwell counter = 0.
- in_ready = en & ~mode & (state != SCAN). This is combinational with no dependence on in_valid.
- Accept = in_valid & in_ready.
- en = 0 at any state:
  - Next edge: state IDLE, out = 0, out_valid = 0, wrap = 0.
  - out_idx keeps its last value.
  - Pending in_valid is not accepted.
- DIRECT, accept in IDLE or HOLD:
  - Next edge: out = 1 << in_sel, out_idx = in_sel, out_valid = 1, state HOLD.
  - Back-to-back accepts update on every edge.
- HOLD without accept: out, out_idx and out_valid are unchanged indefinitely.
- SCAN entry (en = 1, mode = 1, state IDLE or HOLD):
  - Next edge: out = 1 (index 0), out_idx = 0, out_valid = 1, state SCAN.
  - Dwell counter loads dwell.
  - wrap stays 0 on entry.
- SCAN slot timing:
  - The counter decrements every cycle.
  - On the edge where the counter is 0, out_idx increments and out shifts left by one. The counter reloads the current dwell, so dwell is sampled only at slot start.
  - Each slot therefore lasts dwell + 1 cycles; dwell = 0 advances every cycle.
- Wrap-around: from out_idx = OUT_W-1, the next slot is index 0 and out = 1. wrap = 1 for exactly the first cycle of that index-0 slot.
- SCAN exit (mode → 0 while en = 1):
  - Next edge: state HOLD, current out and out_idx frozen, counter cleared.
  - in_ready rises in the cycle after that edge.
- Simultaneous events:
  - mode = 1 with in_valid = 1 in HOLD: in_ready = 0, scan entry wins, and in_sel is ignored.
  - en = 0 overrides every other input.
- Invariant: out is always either all-zero (out_valid = 0) or exactly one-hot equal to 1 << out_idx (out_valid = 1).

## Timing
- DIRECT latency: 1 cycle from accept edge to out.
- SCAN latency: first line 1 cycle after entry; advance period dwell + 1 cycles; full sweep OUT_W*(dwell+1) cycles.
- All outputs are registered except in_ready.
- No combinational path from in_sel or in_valid to out.
- Reset assertion mid-scan clears outputs asynchronously. After rst_n release, the first scan line appears 1 edge after en = 1 and mode = 1 are seen.

## Test plan
- Reset then DIRECT sweep (SEL_W = 3, en = 1, mode = 0): in_sel 0..7 with in_valid each cycle → out = 0x01, 0x02, …, 0x80, one cycle after each accept; out_idx tracks in_sel.
- HOLD and disable: load in_sel = 5 → out = 0x20 held for 20 idle cycles; drop en → next cycle out = 0, out_valid = 0.
- SCAN with dwell = 2: mode = 1 → out = 0x01 for 3 cycles, then 0x02, …, 0x80; wrap = 1 only on the first 0x01 cycle after 0x80, i.e. cycle 25 after entry.
- Dwell = 0 and mid-slot dwell change: out advances every cycle; changing dwell from 0 to 4 mid-scan takes effect at the next slot boundary only.
- SCAN exit and collision: at out = 0x10, mode → 0 → out frozen at 0x10, in_ready = 1 next cycle. With in_valid = 1 and mode → 1 in the same HOLD cycle → in_ready = 0, scan restarts at 0x01.
- Async reset mid-scan: rst_n low at out = 0x40 → out = 0, out_valid = 0 immediately. After release, rst_n high with en = 1 and mode = 1 → out = 0x01 after one edge.
